// File: rtl/clk_en_gen_pkg.sv
// Shared widths, fixed-point helpers and the divisor type for the clock-enable generator.
package clk_en_gen_pkg;

   localparam int CEG_INT_W  = 16;
   localparam int CEG_FRAC_W = 8;
   localparam int CEG_DIV_W  = CEG_INT_W + CEG_FRAC_W;

   // Unsigned INT_W.FRAC_W fixed-point divisor at the default widths.
   typedef logic [CEG_DIV_W-1:0] ceg_div_t;

   // Fixed-point representation of 1.0 for a given number of fractional bits.
   function automatic logic [31:0] ceg_one(input int frac_w);
      return 32'd1 << frac_w;
   endfunction

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int ceg_chan_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One fractional clock-enable channel: accumulator, active divisor, shadow divisor
// and pending flag. The accumulator counts down by 1.0 per cycle and a pulse fires
// whenever less than one cycle of credit remains.
module clk_en_chan
   import clk_en_gen_pkg::*;
#(
   parameter int          INT_W       = CEG_INT_W,
   parameter int          FRAC_W      = CEG_FRAC_W,
   parameter int unsigned DEFAULT_DIV = 16 * ceg_one(CEG_FRAC_W)
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    en_i,
   input  logic                    sync_i,
   input  logic                    wr_i,
   input  logic [INT_W+FRAC_W-1:0] wr_div_i,
   output logic                    pending_o,
   output logic                    pulse_o
);

   localparam int             W       = INT_W + FRAC_W;
   localparam logic [W-1:0]   ONE     = W'(ceg_one(FRAC_W));
   localparam logic [W-1:0]   DIV_RST = W'(DEFAULT_DIV);

   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] div_q, div_d;
   logic [W-1:0] shadow_q, shadow_d;
   logic         pending_q, pending_d;
   logic         pulse_q;

   logic         pulse;
   logic         apply;
   logic [W-1:0] div_new;
   logic [W-1:0] div_eff;

   // Pulse whenever less than one cycle of credit remains; sync and disable both suppress it.
   assign pulse   = en_i && !sync_i && (acc_q < ONE);
   // A pending shadow is promoted at pulse, sync or while disabled.
   assign apply   = !en_i || sync_i || pulse;
   assign div_new = (apply && pending_q) ? shadow_q : div_q;
   // Divisors below 1.0 saturate to 1.0 so the channel simply pulses every cycle.
   assign div_eff = (div_new < ONE) ? ONE : div_new;

   // Next-state: promote shadow at apply points, then advance or clear the accumulator.
   // acc < ONE before the add, so acc + div_eff - ONE < div_eff and never overflows;
   // intermediate wrap of the sum cancels in modulo-2^W arithmetic.
   always_comb begin
      acc_d     = acc_q;
      div_d     = div_new;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (apply) begin
         pending_d = 1'b0;
      end
      if (!en_i || sync_i) begin
         acc_d = '0;
      end else if (pulse) begin
         acc_d = acc_q + div_eff - ONE;
      end else begin
         acc_d = acc_q - ONE;
      end
      // Writes only arrive while nothing is pending, so they never race a promotion.
      if (wr_i) begin
         shadow_d  = wr_div_i;
         pending_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset; the output pulse is the registered condition.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         acc_q     <= '0;
         div_q     <= DIV_RST;
         shadow_q  <= DIV_RST;
         pending_q <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         div_q     <= div_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         pulse_q   <= pulse;
      end
   end

   assign pending_o = pending_q;
   assign pulse_o   = pulse_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator with a shared divisor write port.
// Each channel owns a shadow register; a write is refused while that channel still
// has an unapplied divisor, and writes to nonexistent channels are acked and dropped.
module clk_en_gen
   import clk_en_gen_pkg::*;
#(
   parameter int          CHANNELS    = 2,
   parameter int          INT_W       = CEG_INT_W,
   parameter int          FRAC_W      = CEG_FRAC_W,
   parameter int unsigned DEFAULT_DIV = 16 * ceg_one(FRAC_W),
   localparam int         CW          = ceg_chan_w(CHANNELS)
) (
   input  logic                    clk,
   input  logic                    n_reset,
   input  logic [CHANNELS-1:0]     chan_en,
   input  logic                    sync,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CW-1:0]           cfg_chan,
   input  logic [INT_W+FRAC_W-1:0] cfg_div,
   output logic [CHANNELS-1:0]     cfg_pending,
   output logic [CHANNELS-1:0]     clk_en_out
);

   logic [CHANNELS-1:0] wr;

   // Write decode: ready follows the addressed channel's pending flag; out-of-range is always ready.
   always_comb begin
      cfg_ready = 1'b1;
      wr        = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg_chan == CW'(i)) begin
            cfg_ready = !cfg_pending[i];
            wr[i]     = cfg_valid && !cfg_pending[i];
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      clk_en_chan #(
         .INT_W       (INT_W),
         .FRAC_W      (FRAC_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk_i     (clk),
         .rst_n_i   (n_reset),
         .en_i      (chan_en[g]),
         .sync_i    (sync),
         .wr_i      (wr[g]),
         .wr_div_i  (cfg_div),
         .pending_o (cfg_pending[g]),
         .pulse_o   (clk_en_out[g])
      );
   end

endmodule
